// File: rtl/nios_led_pwm_pio.sv
// Avalon-MM LED output PIO with atomic set/clear/toggle, per-channel PWM dimming
// and a programmable tick prescaler; zero-wait-state combinational reads.
module nios_led_pwm_pio #(
    parameter int                NCH        = 10,
    parameter int                DUTY_W     = 8,
    parameter int                PRESC_W    = 16,
    parameter logic [NCH-1:0]    RESET_DATA = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic [NCH-1:0]     out_port
);

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_SET      = 3'd1,
        ADDR_CLEAR    = 3'd2,
        ADDR_TOGGLE   = 3'd3,
        ADDR_MODE     = 3'd4,
        ADDR_DUTY_SEL = 3'd5,
        ADDR_DUTY_VAL = 3'd6,
        ADDR_PRESCALE = 3'd7
    } reg_addr_t;

    logic                wr_en;
    reg_addr_t           addr;
    logic [NCH-1:0]      data;
    logic [NCH-1:0]      mode;
    logic [4:0]          duty_sel;
    logic [DUTY_W-1:0]   duty [NCH];
    logic [PRESC_W-1:0]  prescale;
    logic [PRESC_W-1:0]  presc_cnt;
    logic [DUTY_W-1:0]   pwm_cnt;
    logic [NCH-1:0]      on;

    assign wr_en = chipselect & ~write_n;
    assign addr  = reg_addr_t'(address);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data     <= RESET_DATA;
            mode     <= '0;
            duty_sel <= '0;
            prescale <= '0;
            // NOTE: the duty table is small and has a defined reset value, so it is
            // reset like any other register rather than inferred as RAM.
            for (int i = 0; i < NCH; i++) duty[i] <= '0;
        end else if (wr_en) begin
            unique case (addr)
                ADDR_DATA:     data     <= writedata[NCH-1:0];
                ADDR_SET:      data     <= data | writedata[NCH-1:0];
                ADDR_CLEAR:    data     <= data & ~writedata[NCH-1:0];
                ADDR_TOGGLE:   data     <= data ^ writedata[NCH-1:0];
                ADDR_MODE:     mode     <= writedata[NCH-1:0];
                ADDR_DUTY_SEL: duty_sel <= writedata[4:0];
                ADDR_DUTY_VAL: begin
                    // An out-of-range selector matches no channel, so the write is dropped.
                    for (int i = 0; i < NCH; i++)
                        if (duty_sel == 5'(i)) duty[i] <= writedata[DUTY_W-1:0];
                end
                ADDR_PRESCALE: prescale <= writedata[PRESC_W-1:0];
                default: ;
            endcase
        end
    end

    // A PRESCALE write restarts the PWM period so the new rate starts cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (wr_en && addr == ADDR_PRESCALE) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (presc_cnt == prescale) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + DUTY_W'(1);
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++)
            on[i] = data[i] & (~mode[i] | (pwm_cnt < duty[i]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_port <= '0;
        else       out_port <= on;
    end

    always_comb begin
        // NOTE: default first so every path assigns readdata and no latch is inferred.
        readdata = '0;
        if (chipselect) begin
            unique case (addr)
                ADDR_DATA:     readdata[NCH-1:0]     = data;
                ADDR_MODE:     readdata[NCH-1:0]     = mode;
                ADDR_DUTY_SEL: readdata[4:0]         = duty_sel;
                ADDR_DUTY_VAL: begin
                    for (int i = 0; i < NCH; i++)
                        if (duty_sel == 5'(i)) readdata[DUTY_W-1:0] = duty[i];
                end
                ADDR_PRESCALE: readdata[PRESC_W-1:0] = prescale;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_led_pwm_pio.sv
// Self-checking bench for nios_led_pwm_pio: directed register/PWM checks followed by
// randomized bus traffic compared against a period-arithmetic reference model.
module tb_nios_led_pwm_pio;

    localparam int NCH = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic [2:0]     address;
    logic           chipselect;
    logic           write_n;
    logic [31:0]    writedata;
    logic [31:0]    readdata;
    logic [NCH-1:0] out_port;

    nios_led_pwm_pio #(
        .NCH        (NCH),
        .DUTY_W     (8),
        .PRESC_W    (16),
        .RESET_DATA (10'h3FF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: register contents plus the number of edges since the PWM
    // period last restarted; the PWM count follows from plain division.
    logic [NCH-1:0] m_data, m_mode, m_out;
    logic [7:0]     m_duty [NCH];
    logic [4:0]     m_sel;
    logic [15:0]    m_presc;
    longint         m_k;
    int             hi_cnt;
    logic [31:0]    last_rd;

    task automatic model_reset();
        m_data  = 10'h3FF;
        m_mode  = '0;
        m_sel   = '0;
        m_presc = '0;
        m_k     = 0;
        m_out   = '0;
        for (int i = 0; i < NCH; i++) m_duty[i] = '0;
    endtask

    function automatic logic [NCH-1:0] model_on();
        longint pwm;
        logic [NCH-1:0] v;
        pwm = (m_k / (longint'(m_presc) + 1)) % 256;
        for (int i = 0; i < NCH; i++)
            v[i] = m_data[i] && (!m_mode[i] || pwm < longint'(m_duty[i]));
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return 32'(m_data);
            3'd4: return 32'(m_mode);
            3'd5: return 32'(m_sel);
            3'd6: return (m_sel < NCH) ? 32'(m_duty[m_sel]) : 32'd0;
            3'd7: return 32'(m_presc);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [2:0] a, input logic [31:0] d);
        case (a)
            3'd0: m_data = d[NCH-1:0];
            3'd1: m_data = m_data | d[NCH-1:0];
            3'd2: m_data = m_data & ~d[NCH-1:0];
            3'd3: m_data = m_data ^ d[NCH-1:0];
            3'd4: m_mode = d[NCH-1:0];
            3'd5: m_sel  = d[4:0];
            3'd6: if (m_sel < NCH) m_duty[m_sel] = d[7:0];
            default: m_presc = d[15:0];
        endcase
    endtask

    // One bus cycle: drive on the falling edge, check readdata mid-cycle, update the
    // model at the rising edge and check out_port just after it.
    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        logic [NCH-1:0] nxt;
        @(negedge clk);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        #1;
        last_rd = readdata;
        check("readdata", readdata, cs ? model_read(a) : 32'd0);
        @(posedge clk);
        nxt = model_on();
        if (cs && !wn) model_write(a, d);
        if (cs && !wn && a == 3'd7) m_k = 0;
        else                        m_k++;
        m_out = nxt;
        #1;
        check("out_port", 32'(out_port), 32'(m_out));
        hi_cnt += int'(out_port[0]);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset      = 1'b1;
        #1;
        model_reset();
        check("out_port_in_reset", 32'(out_port), 32'd0);
        check("readdata_in_reset", readdata, 32'd0);
        @(negedge clk);
        check("out_port_in_reset2", 32'(out_port), 32'd0);
        reset = 1'b0;
        #1;
        check("out_port_after_release", 32'(out_port), 32'd0);
    endtask

    initial begin
        logic [2:0]  a;
        logic [31:0] d;
        logic        cs, wn;

        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        hi_cnt     = 0;
        model_reset();

        // Reset values and release behaviour.
        do_reset();
        idle(1);
        check("reset_data_out", 32'(out_port), 32'h3FF);
        rd(3'd0);
        check("reset_data_read", last_rd, 32'h3FF);

        // Atomic set/clear/toggle.
        wr(3'd0, 32'h005);
        wr(3'd1, 32'h0F0);
        wr(3'd2, 32'h001);
        wr(3'd3, 32'h300);
        rd(3'd0);
        check("sct_read", last_rd, 32'h3F4);
        idle(1);
        check("sct_out", 32'(out_port), 32'h3F4);

        // PWM at duty 64, prescale 0: 64 high cycles in any 256-cycle window.
        wr(3'd4, 32'h001);
        wr(3'd5, 32'd0);
        wr(3'd6, 32'd64);
        wr(3'd7, 32'd0);
        wr(3'd0, 32'h001);
        idle(2);
        hi_cnt = 0;
        idle(256);
        check("duty64_high", 32'(hi_cnt), 32'd64);
        hi_cnt = 0;
        idle(256);
        check("duty64_period", 32'(hi_cnt), 32'd64);

        // Duty extremes.
        wr(3'd6, 32'd0);
        idle(1);
        hi_cnt = 0;
        idle(256);
        check("duty0_high", 32'(hi_cnt), 32'd0);
        wr(3'd6, 32'd255);
        idle(1);
        hi_cnt = 0;
        idle(256);
        check("duty255_high", 32'(hi_cnt), 32'd255);

        // Prescaler: tick every 4 cycles stretches the period to 1024 cycles.
        wr(3'd6, 32'd64);
        wr(3'd7, 32'd3);
        hi_cnt = 0;
        idle(1024);
        check("presc3_high", 32'(hi_cnt), 32'd256);
        idle(100);
        wr(3'd7, 32'd3);
        hi_cnt = 0;
        idle(256);
        check("presc_restart_high", 32'(hi_cnt), 32'd256);
        idle(1);
        check("presc_restart_low", 32'(out_port[0]), 32'd0);

        // Out-of-range duty selector.
        wr(3'd5, 32'd12);
        wr(3'd6, 32'h55);
        rd(3'd6);
        check("sel12_read", last_rd, 32'd0);
        rd(3'd5);
        check("sel12_stored", last_rd, 32'd12);
        wr(3'd5, 32'd0);
        rd(3'd6);
        check("sel0_unchanged", last_rd, 32'd64);

        // Reset mid-PWM, then back to reset values.
        idle(37);
        do_reset();
        idle(1);
        check("rst_mid_out", 32'(out_port), 32'h3FF);
        rd(3'd4);
        check("rst_mid_mode", last_rd, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            a  = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 2) != 0);
            case (a)
                3'd5:    d = 32'($urandom_range(0, 15));
                3'd7:    d = 32'($urandom_range(0, 3));
                default: d = $urandom;
            endcase
            step(cs, wn, a, d);
            if (i == 2000) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
